// File: rtl/wb_interconnect_b3.sv
// Wishbone B3 shared-bus interconnect: N masters arbitrated (round-robin or
// fixed priority) onto one bus, M slaves decoded by base/mask table, with an
// internal error response for unmapped addresses, a per-access watchdog and a
// registered write-snoop port.
module wb_interconnect_b3 #(
    parameter int MASTERS    = 2,
    parameter int SLAVES     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_BASE = '0,
    parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_MASK = '0,
    parameter bit ARB_RR     = 1'b1,
    parameter int TIMEOUT    = 256
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    // master side
    input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]         m_adr_i,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]         m_dat_i,
    input  logic [MASTERS-1:0][DATA_WIDTH/8-1:0]       m_sel_i,
    input  logic [MASTERS-1:0]                         m_we_i,
    input  logic [MASTERS-1:0][2:0]                    m_cti_i,
    input  logic [MASTERS-1:0][1:0]                    m_bte_i,
    input  logic [MASTERS-1:0]                         m_cyc_i,
    input  logic [MASTERS-1:0]                         m_stb_i,
    output logic [MASTERS-1:0][DATA_WIDTH-1:0]         m_dat_o,
    output logic [MASTERS-1:0]                         m_ack_o,
    output logic [MASTERS-1:0]                         m_err_o,
    output logic [MASTERS-1:0]                         m_rty_o,
    // slave side
    output logic [SLAVES-1:0][ADDR_WIDTH-1:0]          s_adr_o,
    output logic [SLAVES-1:0][DATA_WIDTH-1:0]          s_dat_o,
    output logic [SLAVES-1:0][DATA_WIDTH/8-1:0]        s_sel_o,
    output logic [SLAVES-1:0]                          s_we_o,
    output logic [SLAVES-1:0][2:0]                     s_cti_o,
    output logic [SLAVES-1:0][1:0]                     s_bte_o,
    output logic [SLAVES-1:0]                          s_cyc_o,
    output logic [SLAVES-1:0]                          s_stb_o,
    input  logic [SLAVES-1:0][DATA_WIDTH-1:0]          s_dat_i,
    input  logic [SLAVES-1:0]                          s_ack_i,
    input  logic [SLAVES-1:0]                          s_err_i,
    input  logic [SLAVES-1:0]                          s_rty_i,
    // snoop and bus hold
    output logic [ADDR_WIDTH-1:0]                      snoop_adr_o,
    output logic                                       snoop_en_o,
    input  logic                                       bus_hold,
    output logic                                       bus_hold_ack
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int MW        = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int SW        = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_MAX = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [MW-1:0]  M_LAST = MW'(MASTERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          gnt_q, gnt_d;
    logic [MW-1:0]          ptr_q, ptr_d;
    logic                   hold_ack_q, hold_ack_d;
    logic                   err_q, err_d;
    logic [WDW-1:0]         wd_q, wd_d;
    logic [ADDR_WIDTH-1:0]  snoop_adr_q, snoop_adr_d;
    logic                   snoop_en_q, snoop_en_d;

    logic                   gnt_vld;
    logic [ADDR_WIDTH-1:0]  g_adr;
    logic                   g_we;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   hit;
    logic [SW-1:0]          sel_idx;
    logic                   rs_ack, rs_err, rs_rty;
    logic                   fwd_ack, fwd_err, fwd_rty;
    logic                   pending;
    logic                   timeout;
    logic [MW-1:0]          arb_idx;

    // Granted master view; a registered error cycle masks the strobe so a held
    // stb only retries on the cycle after the error.
    always_comb begin
        gnt_vld = (state_q == S_BUSY);
        g_adr   = m_adr_i[gnt_q];
        g_we    = m_we_i[gnt_q];
        g_cyc   = gnt_vld & m_cyc_i[gnt_q];
        g_stb   = g_cyc & m_stb_i[gnt_q] & ~err_q;
    end

    // Address decode: scan high to low so the lowest-index hit wins overlaps.
    always_comb begin
        hit     = 1'b0;
        sel_idx = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if ((S_MASK[i] != '0) &&
                ((g_adr & S_MASK[i]) == (S_BASE[i] & S_MASK[i]))) begin
                hit     = 1'b1;
                sel_idx = SW'(i);
            end
        end
    end

    // Slave fan-out: request fields broadcast, cyc/stb only to the hit slave.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_cyc_o = '0;
        s_stb_o = '0;
        if (gnt_vld) begin
            for (int i = 0; i < SLAVES; i++) begin
                s_adr_o[i] = m_adr_i[gnt_q];
                s_dat_o[i] = m_dat_i[gnt_q];
                s_sel_o[i] = m_sel_i[gnt_q];
                s_we_o[i]  = m_we_i[gnt_q];
                s_cti_o[i] = m_cti_i[gnt_q];
                s_bte_o[i] = m_bte_i[gnt_q];
            end
        end
        if (g_cyc && hit) begin
            s_cyc_o[sel_idx] = 1'b1;
            s_stb_o[sel_idx] = g_stb;
        end
    end

    // Response return: only while strobing (drops late acks), err dominates.
    always_comb begin
        rs_ack  = g_stb & hit & s_ack_i[sel_idx];
        rs_err  = g_stb & hit & s_err_i[sel_idx];
        rs_rty  = g_stb & hit & s_rty_i[sel_idx];
        fwd_err = rs_err | (err_q & g_cyc);
        fwd_ack = rs_ack & ~fwd_err;
        fwd_rty = rs_rty & ~fwd_err;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        m_dat_o = '0;
        if (gnt_vld) begin
            m_ack_o[gnt_q] = fwd_ack;
            m_err_o[gnt_q] = fwd_err;
            m_rty_o[gnt_q] = fwd_rty;
        end
        if (gnt_vld && hit) begin
            for (int m = 0; m < MASTERS; m++) begin
                m_dat_o[m] = s_dat_i[sel_idx];
            end
        end
    end

    // Watchdog and internal error: unmapped strobe or an expired wait both
    // raise a one-cycle registered error toward the granted master.
    always_comb begin
        pending = g_stb & hit & ~(s_ack_i[sel_idx] | s_err_i[sel_idx] | s_rty_i[sel_idx]);
        timeout = 1'b0;
        wd_d    = '0;
        if ((TIMEOUT != 0) && pending) begin
            if (wd_q == WD_MAX) begin
                timeout = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
        err_d = (g_stb & ~hit) | timeout;
    end

    // Write snoop: capture address of every slave-acked write.
    always_comb begin
        snoop_en_d  = fwd_ack & g_we;
        snoop_adr_d = snoop_en_d ? g_adr : snoop_adr_q;
    end

    // Arbiter: first requester at or after the search pointer.
    always_comb begin
        int  j;
        logic found;
        arb_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < MASTERS; k++) begin
            j = (ARB_RR ? int'(ptr_q) : 0) + k;
            if (j >= MASTERS) j = j - MASTERS;
            if (!found && m_cyc_i[MW'(j)]) begin
                found   = 1'b1;
                arb_idx = MW'(j);
            end
        end
    end

    // Bus ownership FSM next-state: grant held for the whole cycle, one idle
    // cycle between owners, hold only taken from IDLE.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_ack_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_hold) begin
                    state_d = S_HOLD;
                end else if (|m_cyc_i) begin
                    gnt_d   = arb_idx;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!m_cyc_i[gnt_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = (!ARB_RR || gnt_q == M_LAST) ? '0 : gnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!bus_hold) state_d = S_IDLE;
                else           hold_ack_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, grant, watchdog and snoop registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            hold_ack_q  <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
            snoop_adr_q <= '0;
            snoop_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            hold_ack_q  <= hold_ack_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
            snoop_adr_q <= snoop_adr_d;
            snoop_en_q  <= snoop_en_d;
        end
    end

    assign bus_hold_ack = hold_ack_q;
    assign snoop_adr_o  = snoop_adr_q;
    assign snoop_en_o   = snoop_en_q;

endmodule

// File: tb/tb_wb_interconnect_b3.sv
// Directed bench for wb_interconnect_b3: arbitration, unmapped error,
// watchdog, snoop, bus hold and mid-transaction reset.
module tb_wb_interconnect_b3;

    localparam int M = 2;
    localparam int S = 4;

    logic                     clk_i;
    logic                     rst_ni;
    logic [M-1:0][31:0]       m_adr_i;
    logic [M-1:0][31:0]       m_dat_i;
    logic [M-1:0][3:0]        m_sel_i;
    logic [M-1:0]             m_we_i;
    logic [M-1:0][2:0]        m_cti_i;
    logic [M-1:0][1:0]        m_bte_i;
    logic [M-1:0]             m_cyc_i;
    logic [M-1:0]             m_stb_i;
    logic [M-1:0][31:0]       m_dat_o;
    logic [M-1:0]             m_ack_o, m_err_o, m_rty_o;
    logic [S-1:0][31:0]       s_adr_o, s_dat_o;
    logic [S-1:0][3:0]        s_sel_o;
    logic [S-1:0]             s_we_o;
    logic [S-1:0][2:0]        s_cti_o;
    logic [S-1:0][1:0]        s_bte_o;
    logic [S-1:0]             s_cyc_o, s_stb_o;
    logic [S-1:0][31:0]       s_dat_i;
    logic [S-1:0]             s_ack_i, s_err_i, s_rty_i;
    logic [31:0]              snoop_adr_o;
    logic                     snoop_en_o;
    logic                     bus_hold, bus_hold_ack;

    logic [S-1:0]             ack_en, err_en, late_ack;
    int                       nchk = 0;
    int                       nerr = 0;

    // Zero-wait slave models: ack/err while strobed, plus a forced late ack.
    assign s_ack_i = (s_stb_o & ack_en) | late_ack;
    assign s_err_i = s_stb_o & err_en;
    assign s_rty_i = '0;
    assign s_dat_i = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

    wb_interconnect_b3 #(
        .MASTERS(M), .SLAVES(S), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .S_BASE({32'h0, 32'h1000_0000, 32'h0000_1000, 32'h0000_0000}),
        .S_MASK({32'h0, 32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .ARB_RR(1'b1), .TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .snoop_adr_o(snoop_adr_o), .snoop_en_o(snoop_en_o),
        .bus_hold(bus_hold), .bus_hold_ack(bus_hold_ack)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; bus_hold = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '1; m_we_i = '0;
        m_cti_i = '0; m_bte_i = '0; m_cyc_i = 2'b11; m_stb_i = 2'b11;
        ack_en = 4'hF; err_en = '0; late_ack = '0;
        #12;
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_m_ack", m_ack_o, 0);
        chk("rst_m_dat", m_dat_o, 0);
        chk("rst_hold_ack", bus_hold_ack, 0);
        chk("rst_snoop_en", snoop_en_o, 0);
        chk("rst_snoop_adr", snoop_adr_o, 0);
        m_cyc_i = '0; m_stb_i = '0;
        tick(); rst_ni = 1'b1;

        // 1: round-robin arbitration
        tick();
        m_adr_i[0] = 32'h10; m_adr_i[1] = 32'h14; m_cyc_i = 2'b11; m_stb_i = 2'b11;
        #1 chk("t1_arb_latency", s_cyc_o, 0);
        tick(); #1;
        chk("t1_m0_ack", m_ack_o, 2'b01);
        chk("t1_m0_stb", s_stb_o, 4'b0001);
        chk("t1_m0_adr", s_adr_o[0], 32'h10);
        chk("t1_dat_bcast", m_dat_o[1], 32'hA000_0000);
        tick(); m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        #1 chk("t1_release", m_ack_o, 0);
        tick(); #1 chk("t1_idle_gap", s_cyc_o, 0);
        tick(); #1;
        chk("t1_m1_ack", m_ack_o, 2'b10);
        chk("t1_m1_adr", s_adr_o[2], 32'h14);
        tick(); m_cyc_i = '0; m_stb_i = '0;
        tick(); m_cyc_i = 2'b11; m_stb_i = 2'b11;
        tick(); #1 chk("t1_rr_wrap", m_ack_o, 2'b01);
        tick(); m_cyc_i = '0; m_stb_i = '0;
        tick();

        // 2: unmapped address
        m_adr_i[0] = 32'hF000_0000; m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        tick(); #1;
        chk("t2_no_stb", s_stb_o, 0);
        chk("t2_no_cyc", s_cyc_o, 0);
        chk("t2_err_early", m_err_o, 0);
        tick(); #1;
        chk("t2_err", m_err_o, 2'b01);
        chk("t2_err_no_stb", s_stb_o, 0);
        tick(); #1 chk("t2_err_pulse", m_err_o, 0);
        tick(); m_cyc_i = '0; m_stb_i = '0;
        tick();

        // 3: watchdog on slave 1 that never acks
        m_adr_i[0] = 32'h0000_1008; ack_en = 4'b1101; m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            #1 chk("t3_wait", {s_stb_o, m_err_o}, {4'b0010, 2'b00});
            tick();
        end
        late_ack = 4'b0010;
        #1;
        chk("t3_timeout_err", m_err_o, 2'b01);
        chk("t3_stb_masked", s_stb_o, 0);
        chk("t3_late_ack_err_cyc", m_ack_o, 0);
        tick(); m_stb_i[0] = 1'b0;
        #1;
        chk("t3_late_ack", m_ack_o, 0);
        chk("t3_err_once", m_err_o, 0);
        tick(); late_ack = '0; m_cyc_i = '0; ack_en = 4'hF;
        tick();

        // 4: write snoop
        m_adr_i[0] = 32'h0000_1004; m_we_i[0] = 1'b1; m_dat_i[0] = 32'hDEAD_BEEF;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        tick(); #1;
        chk("t4_wr_ack", m_ack_o, 2'b01);
        chk("t4_wr_dat", s_dat_o[1], 32'hDEAD_BEEF);
        chk("t4_snoop_early", snoop_en_o, 0);
        tick(); m_stb_i[0] = 1'b0; m_we_i[0] = 1'b0;
        #1;
        chk("t4_snoop_en", snoop_en_o, 1);
        chk("t4_snoop_adr", snoop_adr_o, 32'h0000_1004);
        tick(); m_adr_i[0] = 32'h20; m_stb_i[0] = 1'b1;
        #1;
        chk("t4_rd_ack", m_ack_o, 2'b01);
        chk("t4_snoop_pulse", snoop_en_o, 0);
        tick(); m_stb_i[0] = 1'b0;
        #1;
        chk("t4_rd_no_snoop", snoop_en_o, 0);
        chk("t4_snoop_hold", snoop_adr_o, 32'h0000_1004);
        tick(); m_cyc_i = '0;
        tick();

        // 5: bus_hold during a 4-beat burst with M1 pending
        m_adr_i[0] = 32'h30; m_cti_i[0] = 3'b010; m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        tick();
        bus_hold = 1'b1; m_adr_i[1] = 32'h40; m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) m_cti_i[0] = 3'b111;
            #1;
            chk("t5_beat_ack", m_ack_o, 2'b01);
            chk("t5_no_hold_ack", bus_hold_ack, 0);
            tick();
        end
        m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        #1 chk("t5_burst_done", s_cyc_o, 0);
        tick(); #1;
        chk("t5_idle_ack", bus_hold_ack, 0);
        chk("t5_idle_cyc", s_cyc_o, 0);
        tick(); #1 chk("t5_hold_entry", bus_hold_ack, 0);
        tick(); #1;
        chk("t5_hold_ack", bus_hold_ack, 1);
        chk("t5_m1_blocked", m_ack_o, 0);
        bus_hold = 1'b0;
        tick(); #1 chk("t5_ack_drop", bus_hold_ack, 0);
        tick(); #1 chk("t5_m1_granted", m_ack_o, 2'b10);
        tick(); m_cyc_i = '0; m_stb_i = '0;
        tick();

        // 6: reset mid-burst, then ack+err priority
        m_adr_i[0] = 32'h50; m_cti_i[0] = 3'b010; m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        tick(); #1 chk("t6_pre_ack", m_ack_o, 2'b01);
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_rst_ack", m_ack_o, 0);
        chk("t6_rst_cyc", s_cyc_o, 0);
        chk("t6_rst_stb", s_stb_o, 0);
        chk("t6_rst_adr", s_adr_o[0], 0);
        chk("t6_rst_dat", m_dat_o, 0);
        chk("t6_rst_snoop", snoop_adr_o, 0);
        tick(); tick(); rst_ni = 1'b1;
        #1 chk("t6_rearb_latency", s_cyc_o, 0);
        tick(); #1;
        chk("t6_regrant_ack", m_ack_o, 2'b01);
        chk("t6_regrant_cyc", s_cyc_o, 4'b0001);
        err_en = 4'b0001;
        #1;
        chk("t6_ack_err_err", m_err_o, 2'b01);
        chk("t6_ack_err_noack", m_ack_o, 0);
        err_en = '0; m_cyc_i = '0; m_stb_i = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
